// File: rtl/moore_seq_generator_pkg.sv
// Shared types, default widths and config check for the serial pattern transmitter.
package moore_seq_generator_pkg;

    localparam int unsigned PAT_W_DEF = 8;
    localparam int unsigned LEN_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // A job is sendable only with 1..max_len pattern bits and at least one repetition.
    function automatic logic cfg_valid(input int unsigned len,
                                       input int unsigned reps,
                                       input int unsigned max_len);
        return (len != 0) && (len <= max_len) && (reps != 0);
    endfunction

endpackage

// File: rtl/seq_gen_shifter.sv
// Latched pattern, down-counting bit index and serial bit select.
module seq_gen_shifter
    import moore_seq_generator_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    output logic             bit_nxt_c,
    output logic             last_bit_c
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [PAT_W-1:0] shifted;

    // Load restarts at the MSB; advancing past bit 0 wraps back so the next repetition is ready.
    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        idx_d = idx_q;
        if (load) begin
            pat_d = pattern;
            len_d = pat_len;
            idx_d = pat_len - LEN_W'(1);
        end else if (advance) begin
            idx_d = (idx_q == '0) ? (len_q - LEN_W'(1)) : (idx_q - LEN_W'(1));
        end
        shifted    = pat_d >> idx_d;
        bit_nxt_c  = shifted[0];
        last_bit_c = (idx_q == '0);
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            pat_q <= pat_d;
            len_q <= len_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/moore_seq_generator.sv
// Serial pattern transmitter: Moore FSM with repetition/gap counters and registered outputs.
module moore_seq_generator
    import moore_seq_generator_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic [CNT_W-1:0] gap,
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] gap_len_q, gap_len_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             d_out_q, d_out_d;
    logic             d_valid_q, d_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_c, advance_c;
    logic             bit_nxt_c, last_bit_c;

    seq_gen_shifter #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .advance    (advance_c),
        .pattern    (pattern),
        .pat_len    (pat_len),
        .bit_nxt_c  (bit_nxt_c),
        .last_bit_c (last_bit_c)
    );

    // Next state, counters, and outputs decoded from the next state so they register in step.
    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        load_c    = 1'b0;
        advance_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    rep_d     = rep_cnt;
                    gap_len_d = gap;
                    gap_cnt_d = '0;
                    state_d   = cfg_valid(32'(pat_len), 32'(rep_cnt), PAT_W) ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                advance_c = 1'b1;
                if (last_bit_c) begin
                    if (rep_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        rep_d = rep_q - CNT_W'(1);
                        if (gap_len_q != '0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_len_q;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == CNT_W'(1)) begin
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        d_valid_d = (state_d == ST_SEND);
        busy_d    = (state_d == ST_SEND) || (state_d == ST_GAP);
        done_d    = (state_d == ST_DONE);
        d_out_d   = (state_d == ST_SEND) ? bit_nxt_c : 1'b0;
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rep_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            d_out_q   <= 1'b0;
            d_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_q     <= rep_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            d_out_q   <= d_out_d;
            d_valid_q <= d_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign d_out   = d_out_q;
    assign d_valid = d_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_moore_seq_generator.sv
// Bench for moore_seq_generator: per-cycle queue model plus literal stream checks.
module tb_moore_seq_generator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic [3:0] rep_cnt;
    logic [3:0] gap;
    logic       d_out;
    logic       d_valid;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    moore_seq_generator dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .pat_len (pat_len),
        .rep_cnt (rep_cnt),
        .gap     (gap),
        .d_out   (d_out),
        .d_valid (d_valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each cycle's expected {d_out,d_valid,busy,done}, built when a job is accepted.
    logic [3:0] exp_q[$];
    logic [3:0] cur;

    task automatic build(input logic [7:0] p, input int len, input int rep, input int g);
        if (len < 1 || len > 8 || rep < 1) begin
            exp_q.push_back(4'b0001);
            return;
        end
        for (int r = 0; r < rep; r++) begin
            for (int i = len - 1; i >= 0; i--) exp_q.push_back({p[i], 3'b110});
            if (r < rep - 1) for (int k = 0; k < g; k++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
    endtask

    initial cur = 4'b0;

    // Model advance: a start is taken only when the previous cycle was plain idle.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur = 4'b0;
        end else begin
            if (exp_q.size() == 0 && cur == 4'b0 && start)
                build(pattern, int'(pat_len), int'(rep_cnt), int'(gap));
            cur = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        check("stream", 64'({d_out, d_valid, busy, done}), 64'(cur));
    end

    // Capture of transmitted bits and pulse counts for literal checks.
    logic [63:0] cap;
    int cap_n, done_n, gapbusy_n, busy_n;

    always @(negedge clk) begin
        if (d_valid) begin
            cap = {cap[62:0], d_out};
            cap_n++;
        end
        if (done) done_n++;
        if (busy) busy_n++;
        if (busy && !d_valid) gapbusy_n++;
    end

    task automatic clear_cap();
        cap = '0; cap_n = 0; done_n = 0; gapbusy_n = 0; busy_n = 0;
    endtask

    task automatic job(input logic [7:0] p, input int len, input int rep, input int g, input int ncyc);
        clear_cap();
        pattern = p;
        pat_len = 4'(len);
        rep_cnt = 4'(rep);
        gap     = 4'(g);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (ncyc) @(negedge clk);
    endtask

    function automatic int hits1011();
        int h = 0;
        for (int i = 0; i + 4 <= cap_n; i++) if (cap[i +: 4] == 4'b1011) h++;
        return h;
    endfunction

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; pattern = '0; pat_len = '0; rep_cnt = '0; gap = '0;
        clear_cap();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", 64'({d_out, d_valid, busy, done}), 64'(0));

        // Single repetition with zero-bubble first bit.
        clear_cap();
        pattern = 8'h0B; pat_len = 4'd4; rep_cnt = 4'd1; gap = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_first_bit", 64'({d_out, d_valid, busy}), 64'(3'b111));
        repeat (4) @(negedge clk);
        check("t1_done", 64'({done, busy, d_valid}), 64'(3'b100));
        repeat (2) @(negedge clk);
        check("t1_bits", cap, 64'(4'b1011));
        check("t1_nbits", 64'(cap_n), 64'(4));
        check("t1_done_n", 64'(done_n), 64'(1));

        // Back-to-back repetitions.
        job(8'h0B, 4, 3, 0, 14);
        check("t2_bits", cap, 64'(12'hBBB));
        check("t2_nbits", 64'(cap_n), 64'(12));
        check("t2_hits", 64'(hits1011()), 64'(3));
        check("t2_done_n", 64'(done_n), 64'(1));

        // Gap of two cycles.
        job(8'h0B, 4, 2, 2, 12);
        check("t3_bits", cap, 64'(8'hBB));
        check("t3_gap_cycles", 64'(gapbusy_n), 64'(2));
        check("t3_done_n", 64'(done_n), 64'(1));

        // Invalid configurations.
        job(8'h0B, 0, 1, 0, 3);
        check("t4a_nbits", 64'(cap_n), 64'(0));
        check("t4a_busy", 64'(busy_n), 64'(0));
        check("t4a_done_n", 64'(done_n), 64'(1));
        job(8'h0B, 9, 1, 0, 3);
        check("t4b_nbits", 64'(cap_n), 64'(0));
        check("t4b_done_n", 64'(done_n), 64'(1));
        job(8'h0B, 4, 0, 0, 3);
        check("t4c_nbits", 64'(cap_n), 64'(0));
        check("t4c_busy", 64'(busy_n), 64'(0));
        check("t4c_done_n", 64'(done_n), 64'(1));

        // Start re-asserted and inputs changed mid-job.
        clear_cap();
        pattern = 8'h0B; pat_len = 4'd4; rep_cnt = 4'd2; gap = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; pattern = 8'hFF; pat_len = 4'd8; rep_cnt = 4'd1; gap = 4'd0;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_bits", cap, 64'(8'hBB));
        check("t5_nbits", 64'(cap_n), 64'(8));
        check("t5_done_n", 64'(done_n), 64'(1));

        // Reset during the third bit, then a full-width job.
        clear_cap();
        pattern = 8'h0B; pat_len = 4'd4; rep_cnt = 4'd2; gap = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_outputs", 64'({d_out, d_valid, busy, done}), 64'(0));
        check("t6_bits", cap, 64'(3'b101));
        repeat (2) @(negedge clk);
        check("t6_no_done", 64'(done_n), 64'(0));
        job(8'hA5, 8, 1, 0, 10);
        check("t6_a5_bits", cap, 64'(8'hA5));
        check("t6_a5_nbits", 64'(cap_n), 64'(8));

        // Single-bit patterns.
        job(8'h01, 1, 3, 0, 5);
        check("t7_bits", cap, 64'(3'b111));
        check("t7_nbits", 64'(cap_n), 64'(3));
        job(8'h02, 1, 2, 1, 5);
        check("t7b_nbits", 64'(cap_n), 64'(2));
        check("t7b_bits", cap, 64'(0));
        check("t7b_gap_cycles", 64'(gapbusy_n), 64'(1));

        // Maximum repetition and gap counts.
        job(8'h02, 2, 15, 15, 242);
        check("t8_bits", cap, 64'(30'h2AAAAAAA));
        check("t8_nbits", 64'(cap_n), 64'(30));
        check("t8_gap_cycles", 64'(gapbusy_n), 64'(210));
        check("t8_done_n", 64'(done_n), 64'(1));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
